// File: rtl/mld_15_7_type2_decoder.sv
// rtl/mld_15_7_type2_decoder.sv - serial one-step majority-logic (Type II) decoder for the (15,7) cyclic code
module mld_15_7_type2_decoder #(
    parameter bit OUT_ALL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       out_bit,
    output logic       out_valid,
    output logic       word_start,
    output logic       word_done,
    output logic [2:0] corr_count
);

    localparam logic [3:0] LAST_CNT = OUT_ALL ? 4'd14 : 4'd6;

    typedef enum logic {IDLE, DECODE} state_t;

    state_t      state_q, state_d;
    logic [14:0] ld_buf_q, ld_buf_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [14:0] dec_buf_q, dec_buf_d;
    logic [3:0]  dec_cnt_q, dec_cnt_d;
    logic        out_bit_q, out_bit_d;
    logic        out_valid_q, out_valid_d;
    logic        word_start_q, word_start_d;
    logic        word_done_q, word_done_d;
    logic [2:0]  corr_q, corr_d;

    logic        a1, a2, a3, a4, maj, corrected;
    logic [2:0]  sum;

    always_comb begin
        a1        = dec_buf_q[7] ^ dec_buf_q[8]  ^ dec_buf_q[10] ^ dec_buf_q[14];
        a2        = dec_buf_q[3] ^ dec_buf_q[11] ^ dec_buf_q[12] ^ dec_buf_q[14];
        a3        = dec_buf_q[1] ^ dec_buf_q[5]  ^ dec_buf_q[13] ^ dec_buf_q[14];
        a4        = dec_buf_q[0] ^ dec_buf_q[2]  ^ dec_buf_q[6]  ^ dec_buf_q[14];
        sum       = {2'b00, a1} + {2'b00, a2} + {2'b00, a3} + {2'b00, a4};
        maj       = (sum >= 3'd3);
        corrected = dec_buf_q[14] ^ maj;
    end

    always_comb begin
        state_d      = state_q;
        ld_buf_d     = ld_buf_q;
        load_cnt_d   = load_cnt_q;
        dec_buf_d    = dec_buf_q;
        dec_cnt_d    = dec_cnt_q;
        out_bit_d    = out_bit_q;
        out_valid_d  = 1'b0;
        word_start_d = 1'b0;
        word_done_d  = 1'b0;
        corr_d       = corr_q;

        if (state_q == DECODE) begin
            out_bit_d    = corrected;
            out_valid_d  = 1'b1;
            word_start_d = (dec_cnt_q == 4'd0);
            corr_d       = ((dec_cnt_q == 4'd0) ? 3'd0 : corr_q) + {2'b00, maj};
            dec_buf_d    = {dec_buf_q[13:0], corrected};
            dec_cnt_d    = dec_cnt_q + 4'd1;
            if (dec_cnt_q == LAST_CNT) begin
                word_done_d = 1'b1;
                state_d     = IDLE;
            end
        end

        // A completed load wins over the decode rotation so a new word can start on the same edge.
        if (in_valid) begin
            ld_buf_d = {ld_buf_q[13:0], in_bit};
            if (load_cnt_q == 4'd14) begin
                dec_buf_d  = {ld_buf_q[13:0], in_bit};
                load_cnt_d = 4'd0;
                dec_cnt_d  = 4'd0;
                state_d    = DECODE;
            end else begin
                load_cnt_d = load_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ld_buf_q     <= '0;
            load_cnt_q   <= '0;
            dec_buf_q    <= '0;
            dec_cnt_q    <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
            word_done_q  <= 1'b0;
            corr_q       <= '0;
        end else begin
            state_q      <= state_d;
            ld_buf_q     <= ld_buf_d;
            load_cnt_q   <= load_cnt_d;
            dec_buf_q    <= dec_buf_d;
            dec_cnt_q    <= dec_cnt_d;
            out_bit_q    <= out_bit_d;
            out_valid_q  <= out_valid_d;
            word_start_q <= word_start_d;
            word_done_q  <= word_done_d;
            corr_q       <= corr_d;
        end
    end

    assign out_bit    = out_bit_q;
    assign out_valid  = out_valid_q;
    assign word_start = word_start_q;
    assign word_done  = word_done_q;
    assign corr_count = corr_q;

endmodule

// File: tb/tb_mld_15_7_type2_decoder.sv
// tb/tb_mld_15_7_type2_decoder.sv - scoreboard bench for mld_15_7_type2_decoder (7-bit and 15-bit output builds)
module tb_mld_15_7_type2_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;

    logic       o7_bit, o7_valid, o7_start, o7_done;
    logic [2:0] o7_corr;
    logic       oa_bit, oa_valid, oa_start, oa_done;
    logic [2:0] oa_corr;

    mld_15_7_type2_decoder #(.OUT_ALL(1'b0)) u_dut7 (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .out_bit(o7_bit), .out_valid(o7_valid), .word_start(o7_start),
        .word_done(o7_done), .corr_count(o7_corr)
    );

    mld_15_7_type2_decoder #(.OUT_ALL(1'b1)) u_dut_all (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
        .out_bit(oa_bit), .out_valid(oa_valid), .word_start(oa_start),
        .word_done(oa_done), .corr_count(oa_corr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [14:0] bits;
        int          len;
        int          corr;
    } exp_t;

    typedef struct {
        logic [14:0] rx;
        logic [6:0]  info;
        int          corr;
    } vec_t;

    exp_t q7[$];
    exp_t qa[$];
    int   starts_a[$];
    int   dones_a[$];
    logic [14:0] col [2];
    int          n   [2];

    localparam logic [14:0] GPOLY = 15'b000000111010001;

    function automatic logic [14:0] encode(input logic [6:0] info);
        logic [14:0] c;
        c = {info, 8'h00};
        for (int i = 14; i >= 8; i--)
            if (c[i]) c = c ^ (GPOLY << (i - 8));
        return {info, c[7:0]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [14:0] rx, input logic [6:0] info, input int corr7);
        exp_t e;
        logic [14:0] clean;
        clean  = encode(info);
        e.bits = {8'h00, info};
        e.len  = 7;
        e.corr = corr7;
        q7.push_back(e);
        e.bits = clean;
        e.len  = 15;
        e.corr = $countones(rx ^ clean);
        qa.push_back(e);
    endtask

    task automatic send_word(input logic [14:0] rx, input int max_gap);
        for (int i = 14; i >= 0; i--) begin
            int g;
            g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_bit   = rx[i];
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q7.size() + qa.size()) != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_pending_words", q7.size() + qa.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int which, input logic v, input logic s, input logic d,
                       input logic b, input logic [2:0] c);
        exp_t e;
        if (!reset) begin
            n[which]   = 0;
            col[which] = '0;
            return;
        end
        if (!v) return;
        check($sformatf("word_start_dut%0d_pos%0d", which, n[which]), int'(s), int'(n[which] == 0));
        if (which == 1 && s) starts_a.push_back(cyc);
        col[which] = {col[which][13:0], b};
        n[which]++;
        if (d) begin
            if (which == 1) dones_a.push_back(cyc);
            if ((which == 0 && q7.size() == 0) || (which == 1 && qa.size() == 0)) begin
                check($sformatf("unexpected_word_dut%0d", which), 1, 0);
            end else begin
                e = (which == 0) ? q7.pop_front() : qa.pop_front();
                check($sformatf("word_len_dut%0d", which), n[which], e.len);
                check($sformatf("word_bits_dut%0d", which), int'(col[which]), int'(e.bits));
                check($sformatf("corr_count_dut%0d", which), int'(c), e.corr);
            end
            n[which]   = 0;
            col[which] = '0;
        end
    endtask

    initial begin
        n[0] = 0; n[1] = 0; col[0] = '0; col[1] = '0;
        forever begin
            @(negedge clk);
            mon(0, o7_valid, o7_start, o7_done, o7_bit, o7_corr);
            mon(1, oa_valid, oa_start, oa_done, oa_bit, oa_corr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [4];
        logic [6:0]  info;
        logic [14:0] clean, mask, rx;
        int          nerr, p;

        vecs[0] = '{rx: 15'b100000011101000, info: 7'b1000000, corr: 1'b0};
        vecs[1] = '{rx: 15'b000000011101000, info: 7'b1000000, corr: 1};
        vecs[2] = '{rx: 15'b000000001101000, info: 7'b1000000, corr: 1};
        vecs[3] = '{rx: 15'b000000010001000, info: 7'b0000000, corr: 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid7", o7_valid, 0);
        check("reset_out_bit7", o7_bit, 0);
        check("reset_word_start7", o7_start, 0);
        check("reset_word_done7", o7_done, 0);
        check("reset_corr7", o7_corr, 0);
        check("reset_out_valid_all", oa_valid, 0);
        check("reset_word_done_all", oa_done, 0);
        check("reset_corr_all", oa_corr, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            push_word(vecs[k].rx, vecs[k].info, vecs[k].corr);
            send_word(vecs[k].rx, 0);
            drain();
        end

        for (int w = 0; w < 3; w++) begin
            info  = 7'($urandom);
            clean = encode(info);
            nerr  = $urandom_range(0, 2);
            mask  = '0;
            for (int k = 0; k < nerr; k++) begin
                do p = $urandom_range(0, 14); while (mask[p]);
                mask[p] = 1'b1;
            end
            rx = clean ^ mask;
            push_word(rx, info, $countones(mask[14:8]));
            send_word(rx, 2);
        end
        drain();

        info = 7'b1011001;
        send_word(encode(info), 0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_decoding7", o7_valid, 1);
        reset = 1'b0;
        #1;
        check("reset_mid_decode_valid7", o7_valid, 0);
        check("reset_mid_decode_valid_all", oa_valid, 0);
        q7.delete();
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        info = 7'b0110101;
        push_word(encode(info), info, 0);
        send_word(encode(info), 0);
        drain();

        starts_a.delete();
        dones_a.delete();
        push_word(vecs[0].rx, vecs[0].info, vecs[0].corr);
        push_word(vecs[1].rx, vecs[1].info, vecs[1].corr);
        send_word(vecs[0].rx, 0);
        send_word(vecs[1].rx, 0);
        drain();
        check("all_start_count", starts_a.size(), 2);
        check("all_done_count", dones_a.size(), 2);
        if (starts_a.size() == 2 && dones_a.size() == 2)
            check("all_second_start_after_done", starts_a[1], dones_a[0] + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
